// File: rtl/j68_bus_loader_if.sv
// Command/response byte streams and j68 data-bus signals of the bus loader.
// Latency: none, this is plain wiring between the loader and its environment.
// Backpressure: valid/ready on the byte streams, data_ack stretches bus accesses.
interface j68_bus_loader_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rd_ena;
  logic        wr_ena;
  logic        data_ack;
  logic [1:0]  byte_ena;
  logic [31:0] address;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [2:0]  fc;
  logic        busy;

  // loader side: consumes commands, drives the bus, produces responses
  modport master (
    input  cmd_valid, cmd_data, rsp_ready, data_ack, rd_data,
    output cmd_ready, rsp_valid, rsp_data, rd_ena, wr_ena, byte_ena,
           address, wr_data, fc, busy
  );

  // environment side: command source, response sink and bus responder
  modport slave (
    output cmd_valid, cmd_data, rsp_ready, data_ack, rd_data,
    input  cmd_ready, rsp_valid, rsp_data, rd_ena, wr_ena, byte_ena,
           address, wr_data, fc, busy
  );
endinterface

// File: rtl/j68_bus_loader.sv
// Byte-stream command channel to j68 word/byte bus accesses, with byte responses.
// Latency: bus request one cycle after the last command byte, response one cycle after ack/timeout.
// Backpressure: cmd_ready low outside IDLE/ADDR/DATA; rsp_valid/rsp_data held until rsp_ready.
module j68_bus_loader #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [2:0]  FC_CODE = 3'b101
) (
  input logic              clk,
  input logic              rst,
  input logic              clk_ena,
  j68_bus_loader_if.master lb
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;
  typedef enum logic [1:0] {OP_W, OP_R, OP_B} op_t;

  // last timeout count value before the access is abandoned
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_sh_q, addr_sh_d;
  logic [7:0]  dat_q, dat_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rd_ena_q, rd_ena_d;
  logic        wr_ena_q, wr_ena_d;
  logic [1:0]  byte_ena_q, byte_ena_d;
  logic [31:0] address_q, address_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [2:0]  fc_q, fc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [7:0]  rsp_lo_q, rsp_lo_d;
  logic        rsp_more_q, rsp_more_d;

  logic        cmd_fire;
  logic        rsp_fire;
  logic        op_known;
  op_t         op_in;
  logic        bus_ack;
  logic        bus_to;
  logic        bus_entry;
  logic [31:0] addr_full;
  logic [31:0] bus_addr;

  assign cmd_fire  = lb.cmd_valid & cmd_ready_q & clk_ena;
  assign rsp_fire  = rsp_valid_q & lb.rsp_ready & clk_ena;
  assign op_known  = (lb.cmd_data == 8'h57) || (lb.cmd_data == 8'h52) || (lb.cmd_data == 8'h42);
  assign op_in     = (lb.cmd_data == 8'h52) ? OP_R : (lb.cmd_data == 8'h42) ? OP_B : OP_W;
  assign bus_ack   = (state_q == S_BUS) & clk_ena & lb.data_ack;
  assign bus_to    = (state_q == S_BUS) & clk_ena & ~lb.data_ack & (tcnt_q == TO_LAST);
  assign addr_full = {addr_sh_q[23:0], lb.cmd_data};
  // reads start straight from ADDR, so the final address byte is still on cmd_data
  assign bus_addr  = (state_q == S_ADDR) ? addr_full : addr_sh_q;
  assign bus_entry = (state_q != S_BUS) && (state_d == S_BUS);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state: command byte sequencing, bus completion, response drain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_fire) state_d = op_known ? S_ADDR : S_RESP;
      S_ADDR: if (cmd_fire && cnt_q == 2'd0) state_d = (op_q == OP_R) ? S_BUS : S_DATA;
      S_DATA: if (cmd_fire && cnt_q == 2'd0) state_d = S_BUS;
      S_BUS:  if (bus_ack || bus_to) state_d = S_RESP;
      S_RESP: if (rsp_fire && !rsp_more_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs and datapath: shift registers, bus request, timeout, response bytes
  always_comb begin
    op_d        = op_q;
    cnt_d       = cnt_q;
    addr_sh_d   = addr_sh_q;
    dat_d       = dat_q;
    tcnt_d      = tcnt_q;
    rd_ena_d    = rd_ena_q;
    wr_ena_d    = wr_ena_q;
    byte_ena_d  = byte_ena_q;
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    fc_d        = fc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_more_d  = rsp_more_q;
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          op_d  = op_in;
          cnt_d = 2'd3;
          if (!op_known) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'h3F;
            rsp_more_d  = 1'b0;
          end
        end
      end
      S_ADDR: begin
        if (cmd_fire) begin
          addr_sh_d = addr_full;
          if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
          else               cnt_d = (op_q == OP_W) ? 2'd1 : 2'd0;
        end
      end
      S_DATA: begin
        if (cmd_fire) begin
          dat_d = lb.cmd_data;
          if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
        end
      end
      S_BUS: begin
        if (bus_ack || bus_to) begin
          rd_ena_d    = 1'b0;
          wr_ena_d    = 1'b0;
          byte_ena_d  = 2'b00;
          fc_d        = 3'b000;
          rsp_valid_d = 1'b1;
          rsp_more_d  = 1'b0;
          if (!bus_ack) begin
            rsp_data_d = 8'h21;
          end else if (op_q == OP_R) begin
            rsp_data_d = lb.rd_data[15:8];
            rsp_lo_d   = lb.rd_data[7:0];
            rsp_more_d = 1'b1;
          end else begin
            rsp_data_d = 8'h2E;
          end
        end else if (clk_ena) begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_fire) begin
          if (rsp_more_q) begin
            rsp_data_d = rsp_lo_q;
            rsp_more_d = 1'b0;
          end else begin
            rsp_valid_d = 1'b0;
          end
        end
      end
      default: ;
    endcase

    if (bus_entry) begin
      address_d = {bus_addr[31:1], 1'b0};
      fc_d      = FC_CODE;
      tcnt_d    = 16'd0;
      rd_ena_d  = (op_q == OP_R);
      wr_ena_d  = (op_q != OP_R);
      unique case (op_q)
        OP_W: begin
          byte_ena_d = 2'b11;
          wr_data_d  = {dat_q, lb.cmd_data};
        end
        OP_B: begin
          byte_ena_d = bus_addr[0] ? 2'b01 : 2'b10;
          wr_data_d  = {lb.cmd_data, lb.cmd_data};
        end
        default: byte_ena_d = 2'b11;
      endcase
    end
  end

  // datapath registers; every _d already holds its value when clk_ena is low
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_W;
      cnt_q       <= 2'd0;
      addr_sh_q   <= 32'd0;
      dat_q       <= 8'd0;
      tcnt_q      <= 16'd0;
      cmd_ready_q <= 1'b0;
      rd_ena_q    <= 1'b0;
      wr_ena_q    <= 1'b0;
      byte_ena_q  <= 2'b00;
      address_q   <= 32'd0;
      wr_data_q   <= 16'd0;
      fc_q        <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_lo_q    <= 8'd0;
      rsp_more_q  <= 1'b0;
    end else begin
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      addr_sh_q   <= addr_sh_d;
      dat_q       <= dat_d;
      tcnt_q      <= tcnt_d;
      cmd_ready_q <= cmd_ready_d;
      rd_ena_q    <= rd_ena_d;
      wr_ena_q    <= wr_ena_d;
      byte_ena_q  <= byte_ena_d;
      address_q   <= address_d;
      wr_data_q   <= wr_data_d;
      fc_q        <= fc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_more_q  <= rsp_more_d;
    end
  end

  assign lb.cmd_ready = cmd_ready_q;
  assign lb.rsp_valid = rsp_valid_q;
  assign lb.rsp_data  = rsp_data_q;
  assign lb.rd_ena    = rd_ena_q;
  assign lb.wr_ena    = wr_ena_q;
  assign lb.byte_ena  = byte_ena_q;
  assign lb.address   = address_q;
  assign lb.wr_data   = wr_data_q;
  assign lb.fc        = fc_q;
  assign lb.busy      = (state_q != S_IDLE);

endmodule
